// File: rtl/camera_pkg.sv
// ---------------------------------------------------------------------------
// camera_pkg
// Shared definitions for the camera-to-VGA pixel pipeline.
//   pix_mode_e    : pixel mode encodings driven on the pipe's mode input
//   BLACK / WHITE : single-bit fill values replicated across the pixel width
//   BAR_SHIFT     : h_count bit where the test-bar index starts (64-clock bars)
//   hcount_width  : width of the horizontal counter for a given H_TOTAL
// ---------------------------------------------------------------------------
package camera_pkg;

  typedef enum logic [1:0] {
    MODE_THRESH = 2'd0,
    MODE_INV    = 2'd1,
    MODE_GRAY   = 2'd2,
    MODE_BARS   = 2'd3
  } pix_mode_e;

  localparam logic BLACK = 1'b0;
  localparam logic WHITE = 1'b1;

  localparam int BAR_SHIFT = 6;

  // The horizontal counter is never narrower than 10 bits so the test-bar
  // slice stays in range even for small H_TOTAL values.
  function automatic int hcount_width(input int h_total);
    int w;
    w = $clog2(h_total + 1);
    return (w < 10) ? 10 : w;
  endfunction

endpackage

// File: rtl/pixel_mapper.sv
// ---------------------------------------------------------------------------
// pixel_mapper
// Purely combinational mapping of a luma byte to an output pixel.
//   y_i         : luma byte of the current pair
//   mode_i      : pixel mode (threshold / inverted threshold / gray / bars)
//   threshold_i : luma comparison level for the threshold modes
//   h_count_i   : current horizontal counter, used only by the test bars
//   pixel_o     : OUT_W-bit pixel value
// ---------------------------------------------------------------------------
module pixel_mapper
  import camera_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 3,
  parameter int HC_W   = 10
) (
  input  logic [DATA_W-1:0] y_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] threshold_i,
  input  logic [HC_W-1:0]   h_count_i,
  output logic [OUT_W-1:0]  pixel_o
);

  logic y_bright;
  logic unused_hc;

  assign y_bright = (y_i >= threshold_i);

  // Only the bar slice of the counter matters here; fold the rest away.
  assign unused_hc = ^h_count_i;

  always_comb begin
    pixel_o = {OUT_W{BLACK}};
    case (mode_i)
      MODE_THRESH: pixel_o = y_bright ? {OUT_W{WHITE}} : {OUT_W{BLACK}};
      MODE_INV:    pixel_o = y_bright ? {OUT_W{BLACK}} : {OUT_W{WHITE}};
      MODE_GRAY:   pixel_o = y_i[DATA_W-1 -: OUT_W];
      MODE_BARS:   pixel_o = h_count_i[BAR_SHIFT +: OUT_W];
      default:     pixel_o = {OUT_W{BLACK}};
    endcase
  end

endmodule

// File: rtl/camera_pixel_pipe.sv
// ---------------------------------------------------------------------------
// camera_pixel_pipe
// Converts a camera YUV byte stream into a registered VGA pixel with
// horizontal/vertical sync, a line counter and an end-of-frame pulse.
//   pclk       : sole clock, rising edge
//   reset      : asynchronous, active-high
//   data_in    : camera byte stream (alternating chroma / luma)
//   h_ref      : camera line-valid
//   v_sync     : camera frame sync, active-high
//   mode       : pixel mode (see camera_pkg::pix_mode_e)
//   threshold  : luma level for the threshold modes
//   hs, vs     : registered active-low syncs
//   data_out   : registered pixel, updated only on luma bytes
//   pix_valid  : one-cycle strobe accompanying each data_out update
//   line_count : h_ref lines finished in the current frame (saturating)
//   frame_done : one-cycle pulse after a v_sync rising edge
// ---------------------------------------------------------------------------
module camera_pixel_pipe
  import camera_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 3,
  parameter int H_TOTAL = 784,
  parameter int H_SYNC  = 80,
  parameter int Y_FIRST = 0,
  parameter int LINE_W  = 10
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              h_ref,
  input  logic              v_sync,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] threshold,
  output logic              hs,
  output logic              vs,
  output logic [OUT_W-1:0]  data_out,
  output logic              pix_valid,
  output logic [LINE_W-1:0] line_count,
  output logic              frame_done
);

  localparam int              HC_W    = hcount_width(H_TOTAL);
  localparam logic [HC_W-1:0] H_LAST  = HC_W'(H_TOTAL);
  localparam logic [HC_W-1:0] H_SYNCW = HC_W'(H_SYNC);
  // Byte phase on which the luma byte of a pair arrives.
  localparam logic            Y_PHASE = (Y_FIRST != 0) ? 1'b0 : 1'b1;

  // State
  logic [HC_W-1:0]   h_count_q,    h_count_d;
  logic              hs_q,         hs_d;
  logic              vs_q,         vs_d;
  logic [OUT_W-1:0]  data_out_q,   data_out_d;
  logic              pix_valid_q,  pix_valid_d;
  logic [LINE_W-1:0] line_count_q, line_count_d;
  logic              frame_done_q, frame_done_d;
  logic              phase_q,      phase_d;
  logic              h_ref_q;
  logic              v_sync_q;

  // Decode
  logic             vs_rise;
  logic             href_fall;
  logic             y_byte;
  logic [OUT_W-1:0] mapped_pix;

  assign vs_rise   = v_sync & ~v_sync_q;
  assign href_fall = h_ref_q & ~h_ref;

  // Frame sync suppresses pixel output even if the camera keeps h_ref up.
  assign y_byte = h_ref & (phase_q == Y_PHASE) & ~v_sync;

  pixel_mapper #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .HC_W   (HC_W)
  ) u_mapper (
    .y_i         (data_in),
    .mode_i      (mode),
    .threshold_i (threshold),
    .h_count_i   (h_count_q),
    .pixel_o     (mapped_pix)
  );

  // Horizontal timing
  always_comb begin
    h_count_d = h_count_q;
    if (v_sync) begin
      h_count_d = '0;
    end else if (h_count_q == H_LAST) begin
      h_count_d = '0;
    end else begin
      h_count_d = h_count_q + HC_W'(1);
    end
  end

  always_comb begin
    hs_d = (h_count_q >= H_SYNCW);
    vs_d = ~v_sync;
  end

  // Byte phase / pixel update
  always_comb begin
    // Any idle pclk realigns the pair so each line starts on phase 0.
    phase_d     = h_ref ? ~phase_q : 1'b0;
    pix_valid_d = y_byte;
    data_out_d  = y_byte ? mapped_pix : data_out_q;
  end

  // Line / frame bookkeeping
  always_comb begin
    line_count_d = line_count_q;
    // Frame start takes priority over a line end in the same cycle.
    if (vs_rise) begin
      line_count_d = '0;
    end else if (href_fall && (line_count_q != {LINE_W{1'b1}})) begin
      line_count_d = line_count_q + LINE_W'(1);
    end
    frame_done_d = vs_rise;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_count_q    <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b1;
      data_out_q   <= '0;
      pix_valid_q  <= 1'b0;
      line_count_q <= '0;
      frame_done_q <= 1'b0;
      phase_q      <= 1'b0;
      h_ref_q      <= 1'b0;
      v_sync_q     <= 1'b0;
    end else begin
      h_count_q    <= h_count_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      data_out_q   <= data_out_d;
      pix_valid_q  <= pix_valid_d;
      line_count_q <= line_count_d;
      frame_done_q <= frame_done_d;
      phase_q      <= phase_d;
      h_ref_q      <= h_ref;
      v_sync_q     <= v_sync;
    end
  end

  assign hs         = hs_q;
  assign vs         = vs_q;
  assign data_out   = data_out_q;
  assign pix_valid  = pix_valid_q;
  assign line_count = line_count_q;
  assign frame_done = frame_done_q;

endmodule
